// File: rtl/hdb3_decoding_if.sv
// Symbol/bit bus between the HDB3 encoder and hdb3_decoding.
// Optional error checking in the decoder is enabled by HDB3_DEC_ERR_CHECK_EN.
interface hdb3_decoding_if;
    // Valid-only handshake, no backpressure: the decoder consumes one symbol on
    // every rising edge where encoding_data_instruction=1, and
    // decoding_data_instruction is a single-cycle strobe the sink must take.
    logic [2:0] encoding_data;
    logic       encoding_data_instruction;
    logic       flush;
    logic       decoding_data;
    logic       decoding_data_instruction;
    logic       decoding_err;

    modport master (
        output encoding_data, encoding_data_instruction, flush,
        input  decoding_data, decoding_data_instruction, decoding_err
    );

    modport slave (
        input  encoding_data, encoding_data_instruction, flush,
        output decoding_data, decoding_data_instruction, decoding_err
    );
endinterface

// File: rtl/hdb3_decoding.sv
// HDB3 decoder: 4-stage delay line plus last-mark tracker removes 000V/B00V.
// Define HDB3_DEC_ERR_CHECK_EN to enable illegal-code and V-polarity checking.
module hdb3_decoding #(
    parameter logic [2:0] SYM_ZERO = 3'b000,
    parameter logic [2:0] SYM_POS  = 3'b001,
    parameter logic [2:0] SYM_NEG  = 3'b010
) (
    input  logic              clk,
    input  logic              rst,
    hdb3_decoding_if.slave    bus,
    output logic [1:0]        dbg_last_mark_o
);

    typedef enum logic [1:0] {
        MARK_NONE = 2'd0,
        MARK_POS  = 2'd1,
        MARK_NEG  = 2'd2
    } mark_e;

    logic [3:0] bit_q, bit_d;
    logic [3:0] tag_q, tag_d;
    logic       data_q, data_d;
    logic       inst_q, inst_d;
    logic       err_q, err_d;
    mark_e      last_mark_q, last_mark_d;

    logic  valid, shift, sym_pos, sym_neg, sym_zero, is_mark, is_v, new_bit;
    mark_e pol;

    assign valid    = bus.encoding_data_instruction;
    assign shift    = valid | bus.flush;
    assign sym_pos  = (bus.encoding_data == SYM_POS);
    assign sym_neg  = (bus.encoding_data == SYM_NEG);
    assign sym_zero = (bus.encoding_data == SYM_ZERO);
    assign pol      = sym_pos ? MARK_POS : MARK_NEG;
    assign is_mark  = valid & (sym_pos | sym_neg);
    // A mark repeating the previous polarity is the substituted V; a first mark is never one.
    assign is_v     = is_mark && (last_mark_q != MARK_NONE) && (last_mark_q == pol);
    assign new_bit  = is_mark & ~is_v;

    always_comb begin
        bit_d       = bit_q;
        tag_d       = tag_q;
        data_d      = data_q;
        inst_d      = 1'b0;
        last_mark_d = last_mark_q;
        if (shift) begin
            data_d = bit_q[3];
            inst_d = tag_q[3];
            // Entries moving down are the three symbols before V; clearing them kills a B.
            bit_d  = {bit_q[2:0] & {3{~is_v}}, new_bit};
            tag_d  = {tag_q[2:0], valid};
        end
        if (is_mark) begin
            last_mark_d = pol;
        end
    end

`ifdef HDB3_DEC_ERR_CHECK_EN
    mark_e last_v_q, last_v_d;
    logic  illegal;

    assign illegal = valid & ~(sym_zero | sym_pos | sym_neg);

    always_comb begin
        last_v_d = last_v_q;
        err_d    = illegal | (is_v && (last_v_q == pol));
        if (is_v) begin
            last_v_d = pol;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_v_q <= MARK_NONE;
        end else begin
            last_v_q <= last_v_d;
        end
    end
`else
    logic unused_zero;
    assign unused_zero = sym_zero;
    assign err_d       = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_q       <= '0;
            tag_q       <= '0;
            data_q      <= 1'b0;
            inst_q      <= 1'b0;
            err_q       <= 1'b0;
            last_mark_q <= MARK_NONE;
        end else begin
            bit_q       <= bit_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            inst_q      <= inst_d;
            err_q       <= err_d;
            last_mark_q <= last_mark_d;
        end
    end

    assign bus.decoding_data             = data_q;
    assign bus.decoding_data_instruction = inst_q;
    assign bus.decoding_err              = err_q;
    assign dbg_last_mark_o               = last_mark_q;

endmodule
